// File: rtl/mmio_perf_counters.sv
//==============================================================================
// Module   : mmio_perf_counters
// Brief    : MMIO performance counters (cycle/instr/branch/correct) with
//            1-cycle registered read. Optional macro: PERF_BRANCH_CNT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mmio_perf_counters #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_re,
    input  logic [3:0]  i_we,
    input  logic        i_inst_retire,
    input  logic        i_br_retire,
    input  logic        i_br_correct,
    output logic [31:0] o_rdata,
    output logic        o_rhit
);

    localparam logic [5:0] c_OFF_CYCLE   = 6'h04;  // 0x10
    localparam logic [5:0] c_OFF_INST    = 6'h05;  // 0x14
    localparam logic [5:0] c_OFF_RESET   = 6'h06;  // 0x18
    localparam logic [5:0] c_OFF_BRANCH  = 6'h07;  // 0x1c
    localparam logic [5:0] c_OFF_CORRECT = 6'h08;  // 0x20

    logic [31:0] r_cyc_cnt;
    logic [31:0] r_inst_cnt;
    logic [31:0] w_br_val;
    logic [31:0] w_brc_val;
    logic [31:0] r_rdata;
    logic        r_rhit;

    logic        w_region;
    logic [5:0]  w_off;
    logic        w_hit;
    logic        w_clr;
    logic [31:0] w_rval;

    assign w_region = (i_addr[31:28] == BASE_ADDR[31:28]);
    assign w_off    = i_addr[7:2];

    always_comb begin
        w_hit  = 1'b0;
        w_rval = 32'h0;
        if (w_region) begin
            case (w_off)
                c_OFF_CYCLE:   begin w_hit = 1'b1; w_rval = r_cyc_cnt;  end
                c_OFF_INST:    begin w_hit = 1'b1; w_rval = r_inst_cnt; end
                c_OFF_RESET:   begin w_hit = 1'b1; w_rval = 32'h0;      end
                c_OFF_BRANCH:  begin w_hit = 1'b1; w_rval = w_br_val;   end
                c_OFF_CORRECT: begin w_hit = 1'b1; w_rval = w_brc_val;  end
                default:       begin w_hit = 1'b0; w_rval = 32'h0;      end
            endcase
        end
    end

    // Clear wins over any increment on the same edge.
    assign w_clr = w_hit && (i_we != 4'h0) && (w_off == c_OFF_RESET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt  <= 32'h0;
            r_inst_cnt <= 32'h0;
        end else if (w_clr) begin
            r_cyc_cnt  <= 32'h0;
            r_inst_cnt <= 32'h0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'h1;
            if (i_inst_retire) begin
                r_inst_cnt <= r_inst_cnt + 32'h1;
            end
        end
    end

`ifdef PERF_BRANCH_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_brc_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cnt  <= 32'h0;
            r_brc_cnt <= 32'h0;
        end else if (w_clr) begin
            r_br_cnt  <= 32'h0;
            r_brc_cnt <= 32'h0;
        end else if (i_br_retire) begin
            r_br_cnt <= r_br_cnt + 32'h1;
            if (i_br_correct) begin
                r_brc_cnt <= r_brc_cnt + 32'h1;
            end
        end
    end

    assign w_br_val  = r_br_cnt;
    assign w_brc_val = r_brc_cnt;
`else
    logic w_unused_br;

    assign w_br_val    = 32'h0;
    assign w_brc_val   = 32'h0;
    assign w_unused_br = i_br_retire ^ i_br_correct;
`endif

    // rhit tracks every load (so non-hitting loads report 0); rdata moves only on a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0;
            r_rhit  <= 1'b0;
        end else if (i_re) begin
            r_rhit <= w_hit;
            if (w_hit) begin
                r_rdata <= w_rval;
            end
        end
    end

    logic w_unused_addr;
    assign w_unused_addr = ^{i_addr[27:8], i_addr[1:0]};

    assign o_rdata = r_rdata;
    assign o_rhit  = r_rhit;

endmodule

`default_nettype wire
